uart_rx: RTL

Serial receiver that sits directly downstream of the UART transmitter. It consumes an 8N1 stream (idle high, 1 start bit, 8 data bits LSB-first, 1 stop bit) on the `SER_CLK` domain, using mid-bit sampling. It presents each received byte with a one-cycle valid strobe, and flags framing errors. Its counter scheme, `CLKS_PER_BIT` derivation and reset values match the transmitter, so a TX→RX loopback is bit-exact.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and
// break hold-off. Counter scheme matches the companion transmitter.
module uart_rx #(
  parameter int UART_BAUD    = 9600,
  parameter int CLKS_PER_BIT = 12_000_000 / UART_BAUD
) (
  input  logic       SER_CLK,
  input  logic       RST,
  input  logic       RX_DATA,
  output logic [7:0] RX_BYTE,
  output logic       RX_DV,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [31:0] HALF = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        sync_q, sync_d;
  logic        rx_s_q, rx_s_d;
  logic [31:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_dv_q, rx_dv_d;
  logic        frame_err_q, frame_err_d;

  always_ff @(posedge SER_CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_q      <= rx_s_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    sync_d      = RX_DATA;
    rx_s_d      = sync_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      // Re-check the line at mid start bit so short glitches are rejected.
      S_START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d          = '0;
          shreg_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            rx_byte_d = shreg_q;
            rx_dv_d   = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end

      // A line held low after a bad stop bit must not look like a new start.
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  assign RX_BYTE   = rx_byte_q;
  assign RX_DV     = rx_dv_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule
